game_data_holder: RTL and testbench



---
 rtl/game_data_holder_if.sv | 29 ++
 rtl/game_data_holder.sv | 140 ++++++++++++++
 tb/tb_game_data_holder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_data_holder_if.sv
// Game-state bus between input conditioning, the round controller and the display path.
// The master drives the pulses and levels; the slave returns score, time and status.
interface game_data_holder_if;
    localparam int unsigned SCORE_W = 14;
    localparam int unsigned TIME_W  = 9;
    localparam int unsigned PTS_W   = 4;

    logic               start;
    logic               pause;
    logic               hit;
    logic [PTS_W-1:0]   hit_pts;
    logic               penalty;
    logic [SCORE_W-1:0] score;
    logic [TIME_W-1:0]  g_time;
    logic               running;
    logic               game_over;
    logic               tick_1hz;
    logic [SCORE_W-1:0] hi_score;

    modport master (
        output start, pause, hit, hit_pts, penalty,
        input  score, g_time, running, game_over, tick_1hz, hi_score
    );

    modport slave (
        input  start, pause, hit, hit_pts, penalty,
        output score, g_time, running, game_over, tick_1hz, hi_score
    );
endinterface

// File: rtl/game_data_holder.sv
// Round controller: IDLE/RUN/PAUSE/OVER FSM, saturating score and 1 s countdown.
// Define HIGH_SCORE_EN to build the best-score register; otherwise hi_score is tied to 0.
module game_data_holder #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned GAME_SECONDS = 300,
    parameter int unsigned SCORE_MAX    = 9999,
    parameter int unsigned PENALTY_PTS  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    game_data_holder_if.slave gd
);

    localparam int unsigned SCORE_W = 14;
    localparam int unsigned TIME_W  = 9;
    localparam int unsigned SUM_W   = 15;
    localparam int unsigned PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [PRE_W-1:0]   PRE_TERM  = PRE_W'(CLK_HZ - 1);
    localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(GAME_SECONDS);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic               tick_q, tick_d;
    logic               running_q, game_over_q;

    logic [SUM_W-1:0]        add_c, sub_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [SCORE_W-1:0]      score_upd_c;

    // Net hit/penalty result, clamped to [0, SCORE_MAX].
    always_comb begin
        add_c = '0;
        sub_c = '0;
        if (gd.hit)     add_c = SUM_W'(gd.hit_pts);
        if (gd.penalty) sub_c = SUM_W'(PENALTY_PTS);
        sum_c = $signed({1'b0, score_q}) + $signed(add_c) - $signed(sub_c);
        if (sum_c[SUM_W-1])
            score_upd_c = '0;
        else if (sum_c > $signed(SUM_W'(SCORE_MAX)))
            score_upd_c = SCORE_TOP;
        else
            score_upd_c = sum_c[SCORE_W-1:0];
    end

    // Next-state and next-value logic for the round.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        score_d = score_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (gd.start) begin
                    state_d = S_RUN;
                    score_d = '0;
                    time_d  = TIME_INIT;
                    pre_d   = '0;
                end
            end
            S_RUN: begin
                if (gd.pause) begin
                    state_d = S_PAUSE;
                end else begin
                    score_d = score_upd_c;
                    if (pre_q == PRE_TERM) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (time_q != '0)
                            time_d = time_q - TIME_W'(1);
                        // Final second elapsed: score from this cycle still counts.
                        if (time_q <= TIME_W'(1))
                            state_d = S_OVER;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (!gd.pause)
                    state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            score_q     <= '0;
            time_q      <= TIME_INIT;
            tick_q      <= 1'b0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            score_q     <= score_d;
            time_q      <= time_d;
            tick_q      <= tick_d;
            running_q   <= (state_d == S_RUN);
            game_over_q <= (state_d == S_OVER);
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] hi_q;

    // Capture the final score on the RUN->OVER transition; survives start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hi_q <= '0;
        else if (state_q == S_RUN && state_d == S_OVER && score_d > hi_q)
            hi_q <= score_d;
    end

    assign gd.hi_score = hi_q;
`else
    assign gd.hi_score = '0;
`endif

    assign gd.score     = score_q;
    assign gd.g_time    = time_q;
    assign gd.running   = running_q;
    assign gd.game_over = game_over_q;
    assign gd.tick_1hz  = tick_q;

endmodule

// File: tb/tb_game_data_holder.sv
// Bench for game_data_holder: directed round scenarios plus random play against a reference model.
// A second instance with a long second exercises score saturation at 9999.
module tb_game_data_holder;

    localparam int CLK_HZ = 10;
    localparam int GAME_S = 3;
    localparam int SMAX   = 9999;
    localparam int PEN    = 5;
`ifdef HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_PAUSE = 2;
    localparam int PH_OVER  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    game_data_holder_if gif ();
    game_data_holder_if sif ();

    game_data_holder #(
        .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME_S), .SCORE_MAX(SMAX), .PENALTY_PTS(PEN)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .gd(gif.slave)
    );

    game_data_holder #(
        .CLK_HZ(1000), .GAME_SECONDS(3), .SCORE_MAX(SMAX), .PENALTY_PTS(PEN)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .gd(sif.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: round phase, seconds left, cycles into the current second.
    int m_phase, m_score, m_time, m_sub, m_tick, m_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_score = 0;
        m_time  = GAME_S;
        m_sub   = 0;
        m_tick  = 0;
        m_hi    = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit h, input int pts, input bit pen);
        int v;
        m_tick = 0;
        case (m_phase)
            PH_IDLE, PH_OVER: begin
                if (s) begin
                    m_phase = PH_RUN;
                    m_score = 0;
                    m_time  = GAME_S;
                    m_sub   = 0;
                end
            end
            PH_RUN: begin
                if (p) begin
                    m_phase = PH_PAUSE;
                end else begin
                    v = m_score + (h ? pts : 0) - (pen ? PEN : 0);
                    m_score = (v < 0) ? 0 : ((v > SMAX) ? SMAX : v);
                    m_sub++;
                    if (m_sub == CLK_HZ) begin
                        m_sub  = 0;
                        m_tick = 1;
                        if (m_time > 0) m_time--;
                        if (m_time == 0) begin
                            m_phase = PH_OVER;
                            if (HS && m_score > m_hi) m_hi = m_score;
                        end
                    end
                end
            end
            default: begin
                if (!p) m_phase = PH_RUN;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"},     32'(gif.score),     32'(m_score));
        chk({tag, ".g_time"},    32'(gif.g_time),    32'(m_time));
        chk({tag, ".running"},   32'(gif.running),   32'(m_phase == PH_RUN));
        chk({tag, ".game_over"}, 32'(gif.game_over), 32'(m_phase == PH_OVER));
        chk({tag, ".tick_1hz"},  32'(gif.tick_1hz),  32'(m_tick));
        chk({tag, ".hi_score"},  32'(gif.hi_score),  32'(m_hi));
    endtask

    // One clock of stimulus on the main instance, then model update and full check.
    task automatic cycle(input string tag, input bit s, input bit p, input bit h,
                         input int pts, input bit pen);
        gif.start   = s;
        gif.pause   = p;
        gif.hit     = h;
        gif.hit_pts = 4'(pts);
        gif.penalty = pen;
        @(posedge clk);
        model_step(s, p, h, pts, pen);
        #1;
        check_all(tag);
        gif.start   = 1'b0;
        gif.hit     = 1'b0;
        gif.penalty = 1'b0;
    endtask

    task automatic run_to_over(input string tag);
        int n;
        n = 0;
        while (m_phase != PH_OVER && n < 100) begin
            cycle(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            n++;
        end
        chk({tag, ".reached_over"}, 32'(m_phase == PH_OVER), 32'd1);
    endtask

    task automatic sat_step(input bit h, input int pts, input bit pen);
        sif.hit     = h;
        sif.hit_pts = 4'(pts);
        sif.penalty = pen;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s_before;
        bit pz;

        gif.start = 0; gif.pause = 0; gif.hit = 0; gif.hit_pts = 0; gif.penalty = 0;
        sif.start = 0; sif.pause = 0; sif.hit = 0; sif.hit_pts = 0; sif.penalty = 0;
        model_reset();

        // Reset values, both asynchronously and across clock edges.
        #2 rst_n = 1'b0;
        #1 check_all("rst_async");
        repeat (2) @(posedge clk);
        #1 check_all("rst_hold");
        rst_n = 1'b1;

        // Scoring inputs are ignored in IDLE.
        for (int i = 0; i < 5; i++)
            cycle("idle", 1'b0, 1'b0, 1'b1, int'($urandom_range(15)), 1'($urandom_range(1)));

        // Saturation on the long-second instance while the main one idles.
        sif.start = 1'b1;
        @(posedge clk);
        #1 sif.start = 1'b0;
        chk("sat.running", 32'(sif.running), 32'd1);
        sif.hit = 1'b1; sif.hit_pts = 4'd15;
        repeat (666) @(posedge clk);
        #1 chk("sat.9990", 32'(sif.score), 32'd9990);
        sat_step(1'b1, 5, 1'b0);
        chk("sat.9995", 32'(sif.score), 32'd9995);
        sat_step(1'b1, 15, 1'b0);
        chk("sat.clamp", 32'(sif.score), 32'd9999);
        sat_step(1'b1, 15, 1'b0);
        chk("sat.hold", 32'(sif.score), 32'd9999);
        sat_step(1'b0, 0, 1'b1);
        chk("sat.pen", 32'(sif.score), 32'd9994);
        sif.penalty = 1'b0;
        check_all("after_sat");

        // Full round: ticks every CLK_HZ cycles, OVER at zero, time stays 0.
        cycle("start", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("start.running", 32'(gif.running), 32'd1);
        chk("start.g_time", 32'(gif.g_time), 32'd3);
        for (int k = 1; k <= 30; k++) begin
            cycle("round", 1'b0, 1'b0, 1'b0, 0, 1'b0);
            if (k % 10 == 0) chk("round.tick_due", 32'(gif.tick_1hz), 32'd1);
        end
        chk("round.over", 32'(gif.game_over), 32'd1);
        chk("round.g_time0", 32'(gif.g_time), 32'd0);
        for (int k = 0; k < 50; k++) cycle("over_hold", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("over_hold.g_time0", 32'(gif.g_time), 32'd0);

        // Hits and penalties.
        cycle("start2", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle("hit7a", 1'b0, 1'b0, 1'b1, 7, 1'b0);
        chk("hit7a.val", 32'(gif.score), 32'd7);
        cycle("hit7b", 1'b0, 1'b0, 1'b1, 7, 1'b0);
        chk("hit7b.val", 32'(gif.score), 32'd14);
        cycle("pen", 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("pen.val", 32'(gif.score), 32'd9);
        cycle("start_in_run", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("start_in_run.val", 32'(gif.score), 32'd9);
        run_to_over("r2");
        cycle("start3", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle("hit3", 1'b0, 1'b0, 1'b1, 3, 1'b0);
        cycle("pen_floor", 1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("pen_floor.val", 32'(gif.score), 32'd0);
        cycle("hit_pen", 1'b0, 1'b0, 1'b1, 2, 1'b1);
        chk("hit_pen.val", 32'(gif.score), 32'd0);
        run_to_over("r3");

        // Pause after 4 prescaler cycles; resume lands the tick 6 cycles later.
        cycle("start4", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) cycle("pre4", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 100; k++)
            cycle("paused", 1'b1, 1'b1, 1'($urandom_range(1)), int'($urandom_range(15)),
                  1'($urandom_range(1)));
        chk("paused.g_time", 32'(gif.g_time), 32'd3);
        chk("paused.score", 32'(gif.score), 32'd0);
        cycle("resume", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        n = 0;
        do begin
            cycle("resume_run", 1'b0, 1'b0, 1'b0, 0, 1'b0);
            n++;
        end while (!gif.tick_1hz && n < 20);
        chk("resume.gap", 32'(n), 32'd6);

        // Hit on the final tick counts; hit in first OVER cycle is dropped.
        n = 0;
        while (!(m_time == 1 && m_sub == CLK_HZ - 1) && n < 100) begin
            cycle("to_final", 1'b0, 1'b0, 1'b0, 0, 1'b0);
            n++;
        end
        s_before = m_score;
        cycle("final_hit", 1'b0, 1'b0, 1'b1, 4, 1'b0);
        chk("final_hit.score", 32'(gif.score), 32'(s_before + 4));
        chk("final_hit.over", 32'(gif.game_over), 32'd1);
        cycle("late_hit", 1'b0, 1'b0, 1'b1, 7, 1'b0);
        chk("late_hit.score", 32'(gif.score), 32'(s_before + 4));
        cycle("restart", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("restart.score", 32'(gif.score), 32'd0);
        chk("restart.g_time", 32'(gif.g_time), 32'd3);
        chk("restart.running", 32'(gif.running), 32'd1);

        // Mid-round asynchronous reset with score 12, g_time 2, prescaler 5.
        cycle("pre_rst_hit", 1'b0, 1'b0, 1'b1, 12, 1'b0);
        for (int k = 0; k < 14; k++) cycle("pre_rst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("pre_rst.g_time", 32'(gif.g_time), 32'd2);
        chk("pre_rst.score", 32'(gif.score), 32'd12);
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Best-score tracking across two rounds, cleared by reset.
        cycle("hs_start1", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle("hs_h1", 1'b0, 1'b0, 1'b1, 15, 1'b0);
        cycle("hs_h2", 1'b0, 1'b0, 1'b1, 5, 1'b0);
        run_to_over("hs_r1");
        chk("hs_r1.hi", 32'(gif.hi_score), HS ? 32'd20 : 32'd0);
        cycle("hs_start2", 1'b1, 1'b0, 1'b0, 0, 1'b0);
        cycle("hs_h3", 1'b0, 1'b0, 1'b1, 11, 1'b0);
        run_to_over("hs_r2");
        chk("hs_r2.hi", 32'(gif.hi_score), HS ? 32'd20 : 32'd0);
        #3 rst_n = 1'b0;
        #1 model_reset();
        chk("hs_rst.hi", 32'(gif.hi_score), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random play against the model.
        pz = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(7) == 0) pz = ~pz;
            cycle("rand", ($urandom_range(40) == 0), pz, 1'($urandom_range(1)),
                  int'($urandom_range(15)), ($urandom_range(2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
